// File: rtl/video_timing_checker.sv
// video_timing_checker: receive-side self-test monitor for the colorbar /
// walking-count video source. Measures line/frame geometry, checks pixel
// data against the expected pattern, counts errors and reports lock.
module video_timing_checker #(
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned H_TOTAL     = 1470,
  parameter int unsigned V_ACTIVE    = 728,
  parameter int unsigned V_TOTAL     = 802,
  parameter int unsigned MODE        = 1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        de,
  input  logic [9:0]  data,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        clr_err,
  output logic        locked,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] err_cnt,
  output logic [15:0] meas_h_active,
  output logic [15:0] meas_v_active,
  output logic [15:0] meas_h_total,
  output logic [15:0] meas_v_total
);

  localparam logic [0:0] SEARCH  = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  logic        de1_q, de2_q, hs1_q, hs2_q, vs1_q, vs2_q;
  logic [9:0]  data1_q;

  logic [0:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d, htot_q, htot_d, hper_q, hper_d;
  logic [15:0] vtot_q, vtot_d, vact_q, vact_d;
  logic [15:0] first_len_q, first_len_d, last_len_q, last_len_d;
  logic        len_mm_q, len_mm_d, data_err_q, data_err_d;
  logic [15:0] err_q, err_d;
  logic [15:0] mha_q, mha_d, mva_q, mva_d, mht_q, mht_d, mvt_q, mvt_d;
  logic        close_q, close_d, pend_mm_q, pend_mm_d, pend_err_q, pend_err_d;
  logic        frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic        locked_q, locked_d;
  logic [3:0]  good_q, good_d;

  logic        de_rise, de_fall, hs_rise, vs_rise, mismatch;
  logic [15:0] cur_idx;
  logic [9:0]  exp_pix;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [9:0] colorbar(input logic [15:0] i);
    logic [9:0] v;
    if      (i < 16'd128)  v = 10'h3FF;
    else if (i < 16'd256)  v = 10'h2FF;
    else if (i < 16'd384)  v = 10'h1FF;
    else if (i < 16'd512)  v = 10'h0FF;
    else if (i < 16'd640)  v = 10'h07F;
    else if (i < 16'd768)  v = 10'h03F;
    else if (i < 16'd896)  v = 10'h02F;
    else if (i < 16'd1024) v = 10'h00F;
    else                   v = 10'h000;
    return v;
  endfunction

  // Two-stage input registers; all edge detection compares stage 1 to stage 2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      de1_q <= 1'b0; de2_q <= 1'b0; hs1_q <= 1'b0; hs2_q <= 1'b0;
      vs1_q <= 1'b0; vs2_q <= 1'b0; data1_q <= '0;
    end else begin
      de1_q <= de;    de2_q <= de1_q;
      hs1_q <= hsync; hs2_q <= hs1_q;
      vs1_q <= vsync; vs2_q <= vs1_q;
      data1_q <= data;
    end
  end

  // Measurement, data check, frame close (stage A) and verdict/lock (stage B).
  // A vsync rise closes the frame from the registered accumulators while this
  // cycle's events (de fall, hsync rise, mismatch) seed the new frame.
  always_comb begin
    de_rise  = de1_q & ~de2_q;
    de_fall  = ~de1_q & de2_q;
    hs_rise  = hs1_q & ~hs2_q;
    vs_rise  = vs1_q & ~vs2_q;
    cur_idx  = de_rise ? '0 : idx_q;
    exp_pix  = (MODE == 1) ? cur_idx[9:0] : colorbar(cur_idx);
    mismatch = de1_q && (data1_q != exp_pix);

    state_d      = vs_rise ? MEASURE : state_q;
    idx_d        = de1_q ? sat_inc(cur_idx) : idx_q;
    htot_d       = hs_rise ? 16'd1 : sat_inc(htot_q);
    hper_d       = hs_rise ? htot_q : hper_q;

    vtot_d       = vs_rise ? '0 : vtot_q;
    vact_d       = vs_rise ? '0 : vact_q;
    first_len_d  = vs_rise ? '0 : first_len_q;
    last_len_d   = vs_rise ? '0 : last_len_q;
    len_mm_d     = vs_rise ? 1'b0 : len_mm_q;
    data_err_d   = (vs_rise ? 1'b0 : data_err_q) | mismatch;
    if (hs_rise) vtot_d = sat_inc(vtot_d);
    if (de_fall) begin
      if (vact_d == '0)              first_len_d = idx_q;
      else if (idx_q != first_len_d) len_mm_d    = 1'b1;
      last_len_d = idx_q;
      vact_d     = sat_inc(vact_d);
    end

    if (clr_err)                       err_d = {15'd0, mismatch};
    else if (mismatch)                 err_d = sat_inc(err_q);
    else                               err_d = err_q;

    close_d    = vs_rise && (state_q == MEASURE);
    mha_d      = mha_q;      mva_d     = mva_q;
    mht_d      = mht_q;      mvt_d     = mvt_q;
    pend_mm_d  = pend_mm_q;  pend_err_d = pend_err_q;
    if (close_d) begin
      mha_d      = last_len_q;
      mva_d      = vact_q;
      mht_d      = hper_d;
      mvt_d      = vtot_q;
      pend_mm_d  = len_mm_q;
      pend_err_d = data_err_q;
    end

    frame_done_d = close_q;
    frame_ok_d   = frame_ok_q;
    good_d       = good_q;
    locked_d     = locked_q;
    if (close_q) begin
      frame_ok_d = (mha_q == 16'(H_ACTIVE)) && (mva_q == 16'(V_ACTIVE)) &&
                   (mht_q == 16'(H_TOTAL))  && (mvt_q == 16'(V_TOTAL))  &&
                   !pend_mm_q && !pend_err_q;
      if (!frame_ok_d)                       good_d = '0;
      else if (good_q != 4'(LOCK_FRAMES))    good_d = good_q + 4'd1;
      locked_d = (good_d == 4'(LOCK_FRAMES));
    end
  end

  // State register for everything computed above.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SEARCH;
      idx_q <= '0; htot_q <= '0; hper_q <= '0; vtot_q <= '0; vact_q <= '0;
      first_len_q <= '0; last_len_q <= '0; len_mm_q <= 1'b0; data_err_q <= 1'b0;
      err_q <= '0; mha_q <= '0; mva_q <= '0; mht_q <= '0; mvt_q <= '0;
      close_q <= 1'b0; pend_mm_q <= 1'b0; pend_err_q <= 1'b0;
      frame_done_q <= 1'b0; frame_ok_q <= 1'b0; locked_q <= 1'b0; good_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d; htot_q <= htot_d; hper_q <= hper_d; vtot_q <= vtot_d;
      vact_q <= vact_d; first_len_q <= first_len_d; last_len_q <= last_len_d;
      len_mm_q <= len_mm_d; data_err_q <= data_err_d;
      err_q <= err_d; mha_q <= mha_d; mva_q <= mva_d; mht_q <= mht_d; mvt_q <= mvt_d;
      close_q <= close_d; pend_mm_q <= pend_mm_d; pend_err_q <= pend_err_d;
      frame_done_q <= frame_done_d; frame_ok_q <= frame_ok_d;
      locked_q <= locked_d; good_q <= good_d;
    end
  end

  assign locked        = locked_q;
  assign frame_done    = frame_done_q;
  assign frame_ok      = frame_ok_q;
  assign err_cnt       = err_q;
  assign meas_h_active = mha_q;
  assign meas_v_active = mva_q;
  assign meas_h_total  = mht_q;
  assign meas_v_total  = mvt_q;

endmodule

// File: tb/tb_video_timing_checker.sv
// Directed bench: small-geometry MODE 1 checker (u1) and a 1280-wide MODE 0
// checker (u0) share one generated video stream; each test checks one of them.
`timescale 1ns/1ps
module tb_video_timing_checker;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic de = 1'b0, hsync = 1'b0, vsync = 1'b0, clr_err = 1'b0;
  logic [9:0] data = '0;

  logic locked1, frame_done1, frame_ok1;
  logic [15:0] err_cnt1, mha1, mva1, mht1, mvt1;
  logic locked0, frame_done0, frame_ok0;
  logic [15:0] err_cnt0, mha0, mva0, mht0, mvt0;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, vs_cyc = 0, fd_cnt1 = 0, fd_lat1 = 0, fd_cnt0 = 0;
  logic vs_prev = 1'b0, fd_ok1 = 1'b0, fd_lk1 = 1'b0, fd_ok0 = 1'b0, fd_lk0 = 1'b0;

  video_timing_checker #(.H_ACTIVE(16), .H_TOTAL(25), .V_ACTIVE(8), .V_TOTAL(15),
                         .MODE(1), .LOCK_FRAMES(2)) u1 (
    .clk(clk), .rstn(rstn), .de(de), .data(data), .hsync(hsync), .vsync(vsync),
    .clr_err(clr_err), .locked(locked1), .frame_done(frame_done1), .frame_ok(frame_ok1),
    .err_cnt(err_cnt1), .meas_h_active(mha1), .meas_v_active(mva1),
    .meas_h_total(mht1), .meas_v_total(mvt1));

  video_timing_checker #(.H_ACTIVE(1280), .H_TOTAL(1290), .V_ACTIVE(1), .V_TOTAL(2),
                         .MODE(0), .LOCK_FRAMES(2)) u0 (
    .clk(clk), .rstn(rstn), .de(de), .data(data), .hsync(hsync), .vsync(vsync),
    .clr_err(1'b0), .locked(locked0), .frame_done(frame_done0), .frame_ok(frame_ok0),
    .err_cnt(err_cnt0), .meas_h_active(mha0), .meas_v_active(mva0),
    .meas_h_total(mht0), .meas_v_total(mvt0));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record frame_done events and the vsync edge they follow.
  always @(negedge clk) begin
    vs_prev <= vsync;
    if (vsync && !vs_prev) vs_cyc <= cyc + 1;
    if (frame_done1) begin
      fd_cnt1 <= fd_cnt1 + 1; fd_ok1 <= frame_ok1; fd_lk1 <= locked1; fd_lat1 <= cyc - vs_cyc;
    end
    if (frame_done0) begin
      fd_cnt0 <= fd_cnt0 + 1; fd_ok0 <= frame_ok0; fd_lk0 <= locked0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] pix_model(input int md, input int i);
    logic [9:0] bars [8] = '{10'h3FF, 10'h2FF, 10'h1FF, 10'h0FF, 10'h07F, 10'h03F, 10'h02F, 10'h00F};
    if (md == 1) return 10'(i % 1024);
    if (i >= 1024) return 10'h000;
    return bars[i / 128];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One source frame: active lines first, vsync starts a line after front porch.
  task automatic send_frame(input int ha, input int hfp, input int hsw, input int hbp,
                            input int va, input int vfp, input int vsw, input int vbp,
                            input int md, input int cl, input int cp, input int cx, input int dl);
    int ht, vt;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    for (int ln = 0; ln < vt; ln++) begin
      for (int c = 0; c < ht; c++) begin
        int len, pix;
        logic [9:0] d;
        step();
        len = (ln < va) ? ((ln == dl) ? ha - 1 : ha) : 0;
        pix = (ln == dl && c >= 8) ? c + 1 : c;
        d = pix_model(md, pix);
        if (ln == cl && pix == cp) d = d ^ 10'(cx);
        de    = (c < len);
        data  = (c < len) ? d : '0;
        hsync = (c >= ha + hfp) && (c < ha + hfp + hsw);
        vsync = (ln >= va + vfp) && (ln < va + vfp + vsw);
      end
    end
  endtask

  task automatic frame1(input int cl, input int cp, input int cx, input int dl, input int hfp);
    send_frame(16, hfp, 2, 3, 8, 2, 3, 2, 1, cl, cp, cx, dl);
  endtask

  task automatic frame0(input int cl, input int cp, input int cx);
    send_frame(1280, 4, 2, 4, 1, 0, 1, 0, 0, cl, cp, cx, -1);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    n_tests++; if ({locked1, frame_done1, frame_ok1, err_cnt1, mha1, mva1, mht1, mvt1} !== '0) begin
      n_fail++; $display("FAIL reset_u1: got %0h required 0", {locked1, frame_done1, frame_ok1, err_cnt1, mha1, mva1, mht1, mvt1}); end
    n_tests++; if ({locked0, frame_done0, frame_ok0, err_cnt0, mha0, mva0, mht0, mvt0} !== '0) begin
      n_fail++; $display("FAIL reset_u0: got %0h required 0", {locked0, frame_done0, frame_ok0, err_cnt0, mha0, mva0, mht0, mvt0}); end
    rstn = 1'b1;
  endtask

  task automatic test_clean();
    int c0;
    c0 = fd_cnt1;
    frame1(-1, 0, 0, -1, 4);
    n_tests++; if (fd_cnt1 - c0 !== 0) begin n_fail++; $display("FAIL clean_arm_no_done: got %0d required 0", fd_cnt1 - c0); end
    frame1(-1, 0, 0, -1, 4);
    n_tests++; if (fd_cnt1 - c0 !== 1) begin n_fail++; $display("FAIL clean_done_count: got %0d required 1", fd_cnt1 - c0); end
    n_tests++; if (fd_lat1 !== 2) begin n_fail++; $display("FAIL clean_done_latency: got %0d required 2", fd_lat1); end
    n_tests++; if (fd_ok1 !== 1'b1) begin n_fail++; $display("FAIL clean_ok_f1: got %0b required 1", fd_ok1); end
    n_tests++; if (fd_lk1 !== 1'b0) begin n_fail++; $display("FAIL clean_locked_f1: got %0b required 0", fd_lk1); end
    n_tests++; if ({mha1, mva1, mht1, mvt1} !== {16'd16, 16'd8, 16'd25, 16'd15}) begin
      n_fail++; $display("FAIL clean_meas: got %0d/%0d/%0d/%0d required 16/8/25/15", mha1, mva1, mht1, mvt1); end
    frame1(-1, 0, 0, -1, 4);
    n_tests++; if (fd_cnt1 - c0 !== 2) begin n_fail++; $display("FAIL clean_done_count2: got %0d required 2", fd_cnt1 - c0); end
    n_tests++; if (fd_ok1 !== 1'b1 || frame_ok1 !== 1'b1) begin n_fail++; $display("FAIL clean_ok_f2: got %0b/%0b required 1/1", fd_ok1, frame_ok1); end
    n_tests++; if (fd_lk1 !== 1'b1 || locked1 !== 1'b1) begin n_fail++; $display("FAIL clean_locked_f2: got %0b/%0b required 1/1", fd_lk1, locked1); end
    n_tests++; if (err_cnt1 !== 16'd0) begin n_fail++; $display("FAIL clean_err: got %0d required 0", err_cnt1); end
  endtask

  task automatic test_data_error();
    frame1(3, 5, 1, -1, 4);
    n_tests++; if (err_cnt1 !== 16'd1) begin n_fail++; $display("FAIL derr_err_cnt: got %0d required 1", err_cnt1); end
    n_tests++; if (fd_ok1 !== 1'b0 || fd_lk1 !== 1'b0) begin n_fail++; $display("FAIL derr_ok_locked: got %0b/%0b required 0/0", fd_ok1, fd_lk1); end
    frame1(-1, 0, 0, -1, 4);
    n_tests++; if (fd_ok1 !== 1'b1 || locked1 !== 1'b0) begin n_fail++; $display("FAIL derr_recover1: got %0b/%0b required 1/0", fd_ok1, locked1); end
    frame1(-1, 0, 0, -1, 4);
    n_tests++; if (locked1 !== 1'b1) begin n_fail++; $display("FAIL derr_relock: got %0b required 1", locked1); end
  endtask

  task automatic test_line_drop();
    frame1(-1, 0, 0, 4, 4);
    n_tests++; if (frame_ok1 !== 1'b0 || locked1 !== 1'b0) begin n_fail++; $display("FAIL drop_ok_locked: got %0b/%0b required 0/0", frame_ok1, locked1); end
    n_tests++; if (err_cnt1 !== 16'd8) begin n_fail++; $display("FAIL drop_err_cnt: got %0d required 8", err_cnt1); end
    n_tests++; if (mha1 !== 16'd16 || mva1 !== 16'd8) begin n_fail++; $display("FAIL drop_meas: got %0d/%0d required 16/8", mha1, mva1); end
  endtask

  task automatic test_geometry();
    frame1(-1, 0, 0, -1, 5);
    n_tests++; if (mht1 !== 16'd26) begin n_fail++; $display("FAIL geom_h_total: got %0d required 26", mht1); end
    n_tests++; if (frame_ok1 !== 1'b0) begin n_fail++; $display("FAIL geom_ok: got %0b required 0", frame_ok1); end
    n_tests++; if (mvt1 !== 16'd15 || err_cnt1 !== 16'd8) begin n_fail++; $display("FAIL geom_vt_err: got %0d/%0d required 15/8", mvt1, err_cnt1); end
    frame1(-1, 0, 0, -1, 4);
    frame1(-1, 0, 0, -1, 4);
    n_tests++; if (locked1 !== 1'b1 || mht1 !== 16'd25) begin n_fail++; $display("FAIL geom_relock: got %0b/%0d required 1/25", locked1, mht1); end
  endtask

  task automatic test_reset_mid_line();
    int c0;
    for (int i = 0; i < 5; i++) begin step(); de = 1'b1; data = 10'(i); end
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    n_tests++; if ({locked1, frame_done1, frame_ok1, err_cnt1, mha1, mva1, mht1, mvt1} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %0h required 0", {locked1, frame_done1, frame_ok1, err_cnt1, mha1, mva1, mht1, mvt1}); end
    step(); de = 1'b0; data = '0;
    idle(2);
    rstn = 1'b1;
    idle(2);
    c0 = fd_cnt1;
    frame1(-1, 0, 0, -1, 4);
    n_tests++; if (fd_cnt1 - c0 !== 0) begin n_fail++; $display("FAIL midreset_rearm: got %0d required 0", fd_cnt1 - c0); end
    frame1(-1, 0, 0, -1, 4);
    n_tests++; if (fd_cnt1 - c0 !== 1 || fd_ok1 !== 1'b1) begin n_fail++; $display("FAIL midreset_valid: got %0d/%0b required 1/1", fd_cnt1 - c0, fd_ok1); end
    n_tests++; if ({mha1, mva1, mht1, mvt1} !== {16'd16, 16'd8, 16'd25, 16'd15}) begin
      n_fail++; $display("FAIL midreset_meas: got %0d/%0d/%0d/%0d required 16/8/25/15", mha1, mva1, mht1, mvt1); end
  endtask

  task automatic test_clr_err();
    for (int k = 0; k < 2; k++) begin
      step(); de = 1'b1; data = 10'h005;
      step(); de = 1'b0; data = '0;
      idle(2);
    end
    idle(2);
    n_tests++; if (err_cnt1 !== 16'd2) begin n_fail++; $display("FAIL clr_pre: got %0d required 2", err_cnt1); end
    step(); de = 1'b1; data = 10'h005;
    step(); de = 1'b0; data = '0; clr_err = 1'b1;
    step(); clr_err = 1'b0;
    idle(2);
    n_tests++; if (err_cnt1 !== 16'd1) begin n_fail++; $display("FAIL clr_with_mismatch: got %0d required 1", err_cnt1); end
    step(); clr_err = 1'b1;
    step(); clr_err = 1'b0;
    idle(2);
    n_tests++; if (err_cnt1 !== 16'd0) begin n_fail++; $display("FAIL clr_plain: got %0d required 0", err_cnt1); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65540; i++) begin
      int si;
      step();
      si = (i > 65535) ? 65535 : i;
      de = 1'b1;
      data = 10'(si % 1024) ^ 10'h001;
    end
    step(); de = 1'b0; data = '0;
    idle(3);
    n_tests++; if (err_cnt1 !== 16'hFFFF) begin n_fail++; $display("FAIL err_saturate: got %0h required ffff", err_cnt1); end
  endtask

  task automatic test_colorbar();
    int c0;
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    c0 = fd_cnt0;
    frame0(-1, 0, 0);
    n_tests++; if (fd_cnt0 - c0 !== 0) begin n_fail++; $display("FAIL cb_arm_no_done: got %0d required 0", fd_cnt0 - c0); end
    frame0(-1, 0, 0);
    n_tests++; if (fd_ok0 !== 1'b1 || fd_lk0 !== 1'b0) begin n_fail++; $display("FAIL cb_f1: got %0b/%0b required 1/0", fd_ok0, fd_lk0); end
    frame0(-1, 0, 0);
    n_tests++; if (locked0 !== 1'b1 || err_cnt0 !== 16'd0) begin n_fail++; $display("FAIL cb_locked: got %0b/%0d required 1/0", locked0, err_cnt0); end
    n_tests++; if ({mha0, mva0, mht0, mvt0} !== {16'd1280, 16'd1, 16'd1290, 16'd2}) begin
      n_fail++; $display("FAIL cb_meas: got %0d/%0d/%0d/%0d required 1280/1/1290/2", mha0, mva0, mht0, mvt0); end
    frame0(0, 1024, 10'h00F);
    n_tests++; if (err_cnt0 !== 16'd1 || frame_ok0 !== 1'b0 || locked0 !== 1'b0) begin
      n_fail++; $display("FAIL cb_pix1024: got %0d/%0b/%0b required 1/0/0", err_cnt0, frame_ok0, locked0); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_data_error();
    test_line_drop();
    test_geometry();
    test_reset_mid_line();
    test_clr_err();
    test_saturation();
    test_colorbar();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
